// File: rtl/sync_fifo_reader_if.sv
// Output stream bundle for sync_fifo_reader.
// Ports: m_valid_out/m_data_out/m_last_out from master, m_ready_in from slave.
interface sync_fifo_reader_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  m_valid_out;
    logic                  m_ready_in;
    logic [DATA_WIDTH-1:0] m_data_out;
    logic                  m_last_out;

    modport master (
        output m_valid_out,
        output m_data_out,
        output m_last_out,
        input  m_ready_in
    );

    modport slave (
        input  m_valid_out,
        input  m_data_out,
        input  m_last_out,
        output m_ready_in
    );
endinterface

// File: rtl/sync_fifo_reader.sv
// Pop-side burst controller for a FWFT sync FIFO with a 2-entry output buffer.
// Ports: clk/rst, start/len/abort control, busy/done/aborted status,
// FIFO read port (empty/data/pop), m_if stream master (valid/ready/data/last).
module sync_fifo_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_in,
    input  logic [LEN_WIDTH-1:0]  burst_len_in,
    input  logic                  abort_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  aborted_out,
    input  logic                  fifo_empty_in,
    input  logic [DATA_WIDTH-1:0] fifo_data_in,
    output logic                  fifo_pop_req_out,
    sync_fifo_reader_if.master    m_if
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]            r_state;
    logic [LEN_WIDTH-1:0]  r_rem;
    logic [1:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_d0;
    logic [DATA_WIDTH-1:0] r_d1;
    logic                  r_l0;
    logic                  r_l1;
    logic                  r_done;
    logic                  r_aborted;

    logic w_busy;
    logic w_valid;
    logic w_hs;
    logic w_pop;
    logic w_abort;
    logic w_new_last;

    assign w_busy     = (r_state != S_IDLE);
    assign w_valid    = (r_cnt != 2'd0);
    assign w_hs       = w_valid && m_if.m_ready_in;
    assign w_abort    = abort_in && w_busy;
    assign w_new_last = (r_rem == LEN_WIDTH'(1));
    // Pop never looks at m_ready_in: the buffer slot count alone gates it.
    assign w_pop = (r_state == S_RUN) && !fifo_empty_in &&
                   (r_rem != '0) && (r_cnt != 2'd2) && !abort_in;

    assign busy_out         = w_busy;
    assign done_out         = r_done;
    assign aborted_out      = r_aborted;
    assign fifo_pop_req_out = w_pop;
    assign m_if.m_valid_out = w_valid;
    assign m_if.m_data_out  = r_d0;
    // A drained buffer may keep a stale last flag in the head slot.
    assign m_if.m_last_out  = r_l0 && w_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rem     <= '0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_in && !abort_in) begin
                        if (burst_len_in != '0) begin
                            r_state <= S_RUN;
                            r_rem   <= burst_len_in;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_RUN, S_FLUSH: begin
                    if (abort_in) begin
                        r_state   <= S_IDLE;
                        r_rem     <= '0;
                        r_aborted <= 1'b1;
                    end else begin
                        if (w_pop) begin
                            r_rem <= r_rem - LEN_WIDTH'(1);
                            if (w_new_last) r_state <= S_FLUSH;
                        end
                        if (r_state == S_FLUSH && w_hs && r_l0) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Two-slot buffer, slot 0 is the head; a pop with a simultaneous
    // handshake only happens at count 1, so the new word lands in slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 2'd0;
            r_d0  <= '0;
            r_d1  <= '0;
            r_l0  <= 1'b0;
            r_l1  <= 1'b0;
        end else if (w_abort) begin
            r_cnt <= 2'd0;
        end else begin
            case ({w_pop, w_hs})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_d0 <= fifo_data_in;
                        r_l0 <= w_new_last;
                    end else begin
                        r_d1 <= fifo_data_in;
                        r_l1 <= w_new_last;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_d0  <= r_d1;
                    r_l0  <= r_l1;
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b11: begin
                    r_d0 <= fifo_data_in;
                    r_l0 <= w_new_last;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/sync_fifo_reader.md
Name: sync_fifo_reader

Overview:
- Pop-side controller for the team's synchronous FIFO.
- Drains a programmed number of words from a first-word-fall-through FIFO read port (`pop_req`/`empty`/`data`) and presents them on a registered valid/ready output stream.
- Marks the final word with `last` and signals completion.
- Sits between a `sync_fifo` instance and a downstream consumer (DMA/packet engine) that needs burst-framed data with backpressure.

Parameters:
- `DATA_WIDTH`, 16, width of FIFO data and output stream data.
- `LEN_WIDTH`, 8, width of the burst length field; maximum burst is 2^LEN_WIDTH-1 words.

Ports:
- `clk`  in  1  clock; the block has one clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start_in`  in  1  one-cycle pulse; begins a burst using `burst_len_in`.
- `burst_len_in`  in  `LEN_WIDTH`  number of words to transfer; sampled only when a start is accepted.
- `abort_in`  in  1  one-cycle pulse; terminates the current burst.
- `busy_out`  out  1  high while a burst is active (states RUN and FLUSH).
- `done_out`  out  1  one-cycle pulse on normal burst completion.
- `aborted_out`  out  1  one-cycle pulse on abort completion.
- `fifo_empty_in`  in  1  FIFO empty flag.
- `fifo_data_in`  in  `DATA_WIDTH`  FIFO head word; valid combinationally whenever `fifo_empty_in`=0.
- `fifo_pop_req_out`  out  1  FIFO pop request; combinational.
- `m_valid_out`  out  1  output stream valid.
- `m_ready_in`  in  1  output stream ready.
- `m_data_out`  out  `DATA_WIDTH`  output stream data; registered.
- `m_last_out`  out  1  high with the final word of a burst.

Behaviour:
- **Reset** (`rst`=1 at posedge):
  - state=IDLE, remaining=0, buffer count=0.
  - `busy_out`, `done_out`, `aborted_out`, `m_valid_out`, `m_last_out`, `fifo_pop_req_out` all = 0; `m_data_out` = 0.
  - Reset mid-burst discards buffered words. Words already popped are lost; FIFO contents are untouched.
- **Storage**: 2-entry output buffer holding {data, last}. `m_*` are driven from the head entry. `m_valid_out` = (count != 0).
- **Output handshake**:
  - Handshake occurs on `m_valid_out` && `m_ready_in`.
  - While `m_valid_out`=1 and no handshake, `m_data_out`/`m_last_out` hold stable.
- **Pop rule**:
  - `fifo_pop_req_out` = (state==RUN) && !`fifo_empty_in` && (remaining != 0) && (count < 2) && !`abort_in`.
  - Pop depends only on registered state and FIFO/abort inputs, never on `m_ready_in`.
  - The block never pops an empty FIFO.
- **Popped word**:
  - Written into the buffer at the posedge of the pop cycle, with last = (remaining==1).
  - remaining decrements by 1 on each pop.
- **Count update**: +1 on pop only, -1 on handshake only, unchanged on both or neither.
- **Throughput and latency**:
  - With `m_ready_in`=1 and a non-empty FIFO, steady state is 1 word/cycle.
  - Latency is 1 cycle from pop to `m_valid_out`.
- **FSM transitions**:
  - IDLE → RUN: on `start_in` && `burst_len_in` != 0. Latch remaining = `burst_len_in`.
  - IDLE, `start_in` with `burst_len_in`==0: stay IDLE; `done_out` pulses the next cycle. No pops, no stream activity.
  - RUN → FLUSH: at the posedge where remaining reaches 0, i.e. the final pop.
  - FLUSH → IDLE: on the handshake of the word with last=1; `done_out` is 1 in the following cycle (registered).
  - `start_in` while `busy_out`=1 is ignored and `burst_len_in` is not resampled.
- **Abort**:
  - `abort_in` in RUN or FLUSH: no pop that cycle; next state IDLE; buffer cleared (count=0); remaining=0.
  - `aborted_out` pulses the next cycle; `done_out` stays 0.
  - `abort_in` in IDLE is ignored and takes priority over a simultaneous `start_in` (nothing starts).
- **FIFO empty mid-burst**: RUN waits indefinitely with no pop. `m_valid_out` falls when the buffer drains.
- **Arithmetic**: remaining is `LEN_WIDTH` bits and never wraps, because popping requires remaining != 0.
- **`busy_out`**: 1 in RUN and FLUSH. It falls in the same cycle that `done_out`/`aborted_out` rises.

Test Plan:
- **Basic burst**: FIFO preloaded with 0x0001..0x0004, `burst_len_in`=4, `start_in` pulse, `m_ready_in`=1 → exactly 4 pops on consecutive cycles. Stream emits 0x0001..0x0004, `m_last_out`=1 only on 0x0004. `done_out` is a single pulse one cycle after the last handshake; FIFO retains 0 words and remains error-free.
- **Backpressure**: 8 words, `burst_len_in`=8, `m_ready_in` toggling 1,0,0,1,... → data order and stability are preserved, no pop while count=2, each word is seen exactly once, `m_last_out` comes with word 8.
- **Starved FIFO**: `burst_len_in`=3, FIFO initially empty, then pushes 0xA, 0xB, 0xC spaced 5 cycles apart → `fifo_pop_req_out` is never high while `fifo_empty_in`=1. Stream outputs 0xA, 0xB, 0xC with last on 0xC; `busy_out` stays high throughout.
- **Zero length / ignored start**: `burst_len_in`=0 with `start_in` → no pops, `done_out` pulses the next cycle. A second `start_in` during an active 4-word burst is ignored, and exactly 4 words are transferred.
- **Abort**: 10-word burst, `m_ready_in`=0 after 2 words, `abort_in` asserted → no further pops, `m_valid_out`=0 and `aborted_out`=1 the next cycle, `done_out` never asserted, FIFO retains 10 minus words popped.
- **Reset mid-burst**: `rst`=1 during a RUN state with count=2 → next cycle all outputs are 0 and state is IDLE. A subsequent `start_in` with `burst_len_in`=2 transfers the next two FIFO words correctly.
